mio_bridge: RTL
===============

# mio_bridge

Data-side memory/IO bridge sitting directly downstream of the pipelined core's MIO port. It accepts one load/store request at a time and routes it to the on-chip data RAM or to the peripheral bus. It returns read data with a one-cycle `cpu_ready` completion pulse, which the core uses as its MIO-ready stall release. Unmapped addresses and peripheral timeouts complete with an error flag instead of hanging the pipeline.

## Interface
- `RAM_AW`, 10: RAM word-address width; RAM occupies byte range 0 .. 2^(RAM_AW+2)-1.
- `PER_TAG`, 4'hF: value of addr[31:28] that selects the peripheral bus.
- `TIMEOUT`, 16: maximum number of PER_WAIT cycles before the access is aborted (≥2).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  access request, held by the core until `cpu_ready`.
- `cpu_addr`  in  32  byte address; bits [1:0] ignored.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_wea`  in  4  byte-lane write enables for stores.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data, valid while `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  error flag, valid with `cpu_ready`.
- `busy`  out  1  high in every state except IDLE.
- `ram_en`  out  1  RAM access strobe.
- `ram_wea`  out  4  RAM byte write enables, gated by `ram_en`.
- `ram_addr`  out  RAM_AW  RAM word address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data, valid one cycle after `ram_en`.
- `per_req`  out  1  peripheral request.
- `per_we`  out  1  peripheral write.
- `per_wea`  out  4  peripheral byte enables.
- `per_addr`  out  32  peripheral byte address.
- `per_wdata`  out  32  peripheral write data.
- `per_ack`  in  1  peripheral completion.
- `per_rdata`  in  32  peripheral read data, valid with `per_ack`.

## Operation
- In IDLE with `cpu_req`=1, latch addr/we/wea/wdata into request registers and decode:
  - RAM when addr[31:RAM_AW+2]==0.
  - Peripheral when addr[31:28]==PER_TAG.
  - Otherwise unmapped.
- States: IDLE, RAM_ISSUE, RAM_DATA, PER_WAIT, RESP.
- Transitions:
  - IDLE→RAM_ISSUE on a RAM request.
  - IDLE→PER_WAIT on a peripheral request.
  - IDLE→RESP on an unmapped request, with err=1 and rdata=0.
  - RAM_ISSUE: `ram_en`=1, `ram_addr`=latched addr[RAM_AW+1:2], `ram_wea`=latched wea if store else 0. Store→RESP; load→RAM_DATA.
  - RAM_DATA: capture `ram_rdata` into the rdata register →RESP.
  - PER_WAIT: `per_req`=1 with latched fields, held stable. On `per_ack`: capture `per_rdata` (captured but ignored for stores, rdata=0), err=0 →RESP. Otherwise the wait counter increments; when it reaches TIMEOUT-1 without ack: err=1, rdata=0 →RESP.
  - RESP: `cpu_ready`=1 for exactly one cycle →IDLE. `cpu_req` is ignored in RESP.
- Wait counter: $clog2(TIMEOUT) bits, cleared on entry to PER_WAIT.
- `per_ack` outside PER_WAIT is ignored.
- Byte lanes pass through unchanged; loads always return the full 32-bit word (extension is done by the core).
- All ram_*/per_* strobes are 0 outside their active states; data/address outputs hold their last latched value.

## Timing
- Reset (async, `reset`=0) forces state=IDLE immediately and clears all of the following:
  - `cpu_ready`, `cpu_err`, `busy`
  - `ram_en`, `ram_wea`, `per_req`, `per_we`, `per_wea`
  - `cpu_rdata`, request registers, wait counter
- Reset mid-access drops `per_req`/`ram_en` immediately; the aborted access never reports completion.
- Request accepted at edge 0 (IDLE, req=1). Latency to the cycle in which `cpu_ready` is high:
  - RAM store: 2 cycles.
  - RAM load: 3 cycles.
  - Unmapped: 1 cycle.
  - Peripheral: 2+k cycles, where `per_ack` arrives in the k-th PER_WAIT cycle (k≥0).
  - Timeout: 1+TIMEOUT cycles.
- `cpu_ready`, `cpu_err` and `cpu_rdata` are registered outputs, with no combinational path from any input.
- Back-to-back: a `cpu_req` held high through RESP is accepted in the following IDLE cycle, giving a minimum of one idle cycle between transactions.

## Test plan
- RAM store then load: store 0x12345678, wea=4'hF to 0x0000_0040, then load from 0x40. Store: `ram_en`+`ram_wea`=F with `ram_addr`=0x10, ready 2 cycles after accept. Load: rdata=0x12345678, ready 3 cycles after accept, err=0.
- Byte store: wea=4'b0100 to 0x44 → `ram_wea`=4'b0100, `ram_addr`=0x11. A following load returns only byte 2 modified.
- Peripheral read: addr 0xF000_0008, ack with rdata 0xCAFEBABE in the 3rd PER_WAIT cycle. Expect `per_req` high 3 cycles with stable addr, then ready with rdata=0xCAFEBABE, err=0.
- Timeout: peripheral write, no ack, TIMEOUT=16 → `per_req` high exactly 16 cycles, then ready with err=1, rdata=0.
- Unmapped load: addr 0x8000_0000 → no ram/per strobes; ready next-after-accept cycle, err=1, rdata=0.
- Reset mid PER_WAIT: pull `reset` low → `per_req`, `busy`, `cpu_ready` go 0 without waiting for a clock edge. After release the bridge is in IDLE and a new RAM load completes normally.

Source files
------------

// File: rtl/mio_bridge.sv
// Data-side memory/IO bridge: routes one core load/store at a time to the on-chip RAM or the
// peripheral bus, and completes with a registered one-cycle ready pulse plus an error flag.
module mio_bridge #(
    parameter int unsigned RAM_AW  = 10,
    parameter logic [3:0]  PER_TAG = 4'hF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [31:0]       cpu_addr,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_wea,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic              busy,
    output logic              ram_en,
    output logic [3:0]        ram_wea,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              per_req,
    output logic              per_we,
    output logic [3:0]        per_wea,
    output logic [31:0]       per_addr,
    output logic [31:0]       per_wdata,
    input  logic              per_ack,
    input  logic [31:0]       per_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StRamIssue,
        StRamData,
        StPerWait,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        wea_q, wea_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              is_ram, is_per;

    assign is_ram = (cpu_addr[31:RAM_AW+2] == '0);
    assign is_per = (cpu_addr[31:28] == PER_TAG);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wea_d   = wea_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wea_d   = cpu_wea;
                    wdata_d = cpu_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (is_ram) begin
                        state_d = StRamIssue;
                    end else if (is_per) begin
                        state_d = StPerWait;
                    end else begin
                        state_d = StResp;
                        err_d   = 1'b1;
                    end
                end
            end
            StRamIssue: state_d = we_q ? StResp : StRamData;
            StRamData: begin
                rdata_d = ram_rdata;
                state_d = StResp;
            end
            StPerWait: begin
                if (per_ack) begin
                    rdata_d = we_q ? 32'h0 : per_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Ready is a flop so the core never sees a combinational path from the buses.
        ready_d = (state_d == StResp);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wea_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wea_q   <= wea_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign cpu_err   = err_q;
    assign busy      = (state_q != StIdle);

    assign ram_en    = (state_q == StRamIssue);
    assign ram_wea   = (ram_en && we_q) ? wea_q : 4'b0000;
    assign ram_addr  = addr_q[RAM_AW+1:2];
    assign ram_wdata = wdata_q;

    assign per_req   = (state_q == StPerWait);
    assign per_we    = per_req & we_q;
    assign per_wea   = per_req ? wea_q : 4'b0000;
    assign per_addr  = addr_q;
    assign per_wdata = wdata_q;

endmodule
